calc_result_display: RTL and testbench
======================================

Name: calc_result_display

Overview:
- Downstream consumer of the calculator's arithmetic units (rem, div, mul, add/sub).
- Accepts one 5-bit sign-magnitude result plus its error flag (e.g. divide-by-zero) via a valid/ready handshake.
- Converts the magnitude to tens/units with an iterative subtract-10 sequencer.
- Drives a 4-digit, time-multiplexed, active-low 7-segment display.

Parameters:
- REFRESH_DIV, 16: clock cycles each digit stays enabled; board builds use 50000.
- BLINK_FRAMES, 8: full 4-digit scan frames per blink half-period; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- res_valid  input  1  upstream result is valid.
- res_data  input  5  sign-magnitude result; bit4 = sign, bits3:0 = magnitude 0..15.
- res_err  input  1  result is an error (divide-by-zero); res_data is ignored when set.
- res_ready  output  1  block can accept a result.
- seg_n  output  7  segments gfedcba, active low.
- an_n  output  4  digit enables, active low; an_n[3] is the leftmost digit.

Behaviour:
- Reset: asynchronous on rst_n low, takes effect immediately.
  - Sequencer goes to IDLE; res_ready=1.
  - All four display digit registers = BLANK; seg_n=7'h7F.
  - Digit index 0, an_n=4'b1110; refresh counter and blink counter = 0.
- Handshake: a result is captured on the rising edge where res_valid&&res_ready. res_valid while res_ready=0 is ignored; upstream holds it.
- FSM:
  - IDLE: res_ready=1. On capture: work=res_data[3:0], tens=0, sign=res_data[4], err=res_err; go to CONV.
  - CONV: res_ready=0. Each cycle:
    - if !err and work>=10: work=work-10, tens=tens+1, stay in CONV;
    - else commit the display registers and return to IDLE.
  - Latency, capture edge to display update: 1 cycle for magnitude <10 or error; 2 cycles for magnitude 10..15. res_ready rises on the commit edge.
- Commit mapping, normal result:
  - digit3 = MINUS if sign && magnitude!=0, else BLANK; negative zero shows as "0".
  - digit2 = BLANK.
  - digit1 = tens if tens!=0, else BLANK.
  - digit0 = units; always shown.
- Commit mapping, error: digit3=BLANK, digit2=E, digit1=r, digit0=r.
- Display registers hold the previous value throughout CONV; there is no partial update.
- Segment codes (gfedcba, active low):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Symbols: MINUS=3F, E=06, r=2F, BLANK=7F.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0→1→2→3→0.
  - an_n = ~(1<<index); seg_n = code of digit[index].
  - Scanning runs continuously and independently of the FSM.
- Reset mid-CONV: conversion aborts; display is blank; no commit occurs.

Optional Feature:
- Macro: CALC_ERR_BLINK_EN.
- Defined:
  - A frame counter counts completed scans (index 3→0 wraps).
  - Every BLINK_FRAMES frames the blink phase toggles.
  - While the committed value is an error and the phase is 1, seg_n is forced to 7F; an_n still scans.
  - Blink phase resets to 0 on each commit.
- Undefined: the error pattern is shown steadily; no frame or blink logic is present.

Test Plan:
- Reset → res_ready=1, an_n=1110, seg_n=7F. After REFRESH_DIV cycles → an_n=1101.
- res_data=5'b00011 (+3) → 1 cycle later res_ready=1 again. Scan shows digit0=30 and digits1..3=7F.
- res_data=5'b11101 (-13) → res_ready low for 2 cycles. Scan shows digit3=3F, digit2=7F, digit1=79, digit0=30.
- res_err=1, res_data=5'b10101 → digits 3..0 = 7F, 06, 2F, 2F. With CALC_ERR_BLINK_EN, all-7F frames alternate every 8 frames.
- res_data=5'b10000 (-0) → digit0=40, digit3=7F; no minus shown.
- Second res_valid held during CONV of 14 → ignored until res_ready=1, then captured. rst_n pulsed low mid-CONV → display blank, res_ready=1 immediately.

Source files
------------

// File: rtl/calc_result_display.sv
// calc_result_display: accepts one sign-magnitude calculator result, splits the
// magnitude into tens/units with a subtract-10 sequencer and drives a 4-digit
// multiplexed active-low 7-segment display (an_n[3] is the leftmost digit).
// Optional feature macro: CALC_ERR_BLINK_EN (blinks the error pattern).
module calc_result_display #(
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [4:0] res_data,
    input  logic       res_err,
    output logic       res_ready,
    output logic [6:0] seg_n,
    output logic [3:0] an_n
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Display symbols: 0..9 are decimal digits, the rest are glyphs.
    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_E     = 4'd11;
    localparam logic [3:0] SYM_R     = 4'd12;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state;
    logic [3:0]    work;
    logic [3:0]    tens;
    logic          sign;
    logic          err;
    logic [3:0]    digit     [4];
    logic [3:0]    digit_nxt [4];
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    index;
    logic [1:0]    index_nxt;
    logic          wrap_c;
    logic          commit_c;
    logic          blank_c;

    // Segment pattern (gfedcba, active low) for one display symbol.
    function automatic logic [6:0] seg_code(input logic [3:0] sym);
        case (sym)
            4'd0:      seg_code = 7'h40;
            4'd1:      seg_code = 7'h79;
            4'd2:      seg_code = 7'h24;
            4'd3:      seg_code = 7'h30;
            4'd4:      seg_code = 7'h19;
            4'd5:      seg_code = 7'h12;
            4'd6:      seg_code = 7'h02;
            4'd7:      seg_code = 7'h78;
            4'd8:      seg_code = 7'h00;
            4'd9:      seg_code = 7'h10;
            SYM_MINUS: seg_code = 7'h3F;
            SYM_E:     seg_code = 7'h06;
            SYM_R:     seg_code = 7'h2F;
            default:   seg_code = 7'h7F;
        endcase
    endfunction

    assign commit_c  = (state == CONV) && (err || (work < 4'd10));
    assign wrap_c    = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign index_nxt = wrap_c ? index + 2'd1 : index;

    // Next display contents: only the commit cycle changes them.
    always_comb begin
        digit_nxt = digit;
        if (commit_c) begin
            if (err) begin
                digit_nxt[3] = SYM_BLANK;
                digit_nxt[2] = SYM_E;
                digit_nxt[1] = SYM_R;
                digit_nxt[0] = SYM_R;
            end else begin
                // Negative zero is shown without the minus sign.
                digit_nxt[3] = (sign && ((tens != 4'd0) || (work != 4'd0))) ? SYM_MINUS : SYM_BLANK;
                digit_nxt[2] = SYM_BLANK;
                digit_nxt[1] = (tens != 4'd0) ? tens : SYM_BLANK;
                digit_nxt[0] = work;
            end
        end
    end

    // Handshake and subtract-10 conversion sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_ready <= 1'b1;
            work      <= 4'd0;
            tens      <= 4'd0;
            sign      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (res_valid && res_ready) begin
                        work      <= res_data[3:0];
                        tens      <= 4'd0;
                        sign      <= res_data[4];
                        err       <= res_err;
                        res_ready <= 1'b0;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    if (commit_c) begin
                        res_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        work <= work - 4'd10;
                        tens <= tens + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Committed display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) digit[i] <= SYM_BLANK;
        end else begin
            digit <= digit_nxt;
        end
    end

`ifdef CALC_ERR_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic          shown_err;
    logic          frame_wrap_c;
    logic          frame_last_c;

    assign frame_wrap_c = wrap_c && (index == 2'd3);
    assign frame_last_c = (frame_cnt == FW'(BLINK_FRAMES - 1));

    // Blink phase: toggles every BLINK_FRAMES scan frames, restarts on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
            shown_err <= 1'b0;
        end else if (commit_c) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
            shown_err <= err;
        end else if (frame_wrap_c) begin
            if (frame_last_c) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Blank the segments when the error pattern is in its dark phase.
    always_comb begin
        blank_c = 1'b0;
        if (commit_c) begin
            blank_c = 1'b0;
        end else if (shown_err) begin
            blank_c = (frame_wrap_c && frame_last_c) ? ~phase : phase;
        end
    end
`else
    logic unused_blink;

    // Keeps the blink parameter referenced in builds without blinking.
    assign unused_blink = |BLINK_FRAMES;
    assign blank_c      = 1'b0;
`endif

    // Digit scan; outputs are registered from next-state values so that
    // seg_n always matches the digit currently enabled on an_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            index       <= 2'd0;
            an_n        <= 4'b1110;
            seg_n       <= 7'h7F;
        end else begin
            refresh_cnt <= wrap_c ? '0 : refresh_cnt + RW'(1);
            index       <= index_nxt;
            an_n        <= ~(4'b0001 << index_nxt);
            seg_n       <= blank_c ? 7'h7F : seg_code(digit_nxt[index_nxt]);
        end
    end

endmodule

// File: tb/tb_calc_result_display.sv
// Testbench for calc_result_display: directed and random results against a
// behavioural model of the expected display contents and scan position.
module tb_calc_result_display;

    localparam int unsigned RD = 16;
    localparam int unsigned BF = 8;
`ifdef CALC_ERR_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid = 1'b0;
    logic [4:0] res_data = 5'd0;
    logic       res_err = 1'b0;
    logic       res_ready;
    logic [6:0] seg_n;
    logic [3:0] an_n;

    always #5 clk = ~clk;

    calc_result_display #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_ready (res_ready),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    // Clock edges since reset release; the scan position follows from it.
    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int          total = 0;
    int          bad = 0;
    logic [6:0]  exp_disp [4];
    logic        exp_err = 1'b0;
    int unsigned cyc_c = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] digit_code(input int unsigned d);
        case (d)
            0: digit_code = 7'h40;
            1: digit_code = 7'h79;
            2: digit_code = 7'h24;
            3: digit_code = 7'h30;
            4: digit_code = 7'h19;
            5: digit_code = 7'h12;
            6: digit_code = 7'h02;
            7: digit_code = 7'h78;
            8: digit_code = 7'h00;
            default: digit_code = 7'h10;
        endcase
    endfunction

    // Expected segments for digit k, including the blink dark phase.
    function automatic logic [6:0] exp_seg(input int unsigned k);
        int unsigned frames;
        frames = (cyc / (4 * RD)) - (cyc_c / (4 * RD));
        exp_seg = exp_disp[k];
        if (BLINK && exp_err && (((frames / BF) % 2) == 1)) exp_seg = 7'h7F;
    endfunction

    // Model of what a committed result shows, computed arithmetically.
    task automatic commit_model(input logic e, input logic [4:0] d);
        int unsigned mag;
        mag = int'(d[3:0]);
        if (e) begin
            exp_disp[3] = 7'h7F; exp_disp[2] = 7'h06;
            exp_disp[1] = 7'h2F; exp_disp[0] = 7'h2F;
        end else begin
            exp_disp[3] = (d[4] && mag != 0) ? 7'h3F : 7'h7F;
            exp_disp[2] = 7'h7F;
            exp_disp[1] = (mag / 10 != 0) ? digit_code(mag / 10) : 7'h7F;
            exp_disp[0] = digit_code(mag % 10);
        end
        exp_err = e;
        cyc_c   = cyc;
    endtask

    task automatic check_scan(input int n, input string tag);
        int unsigned idx;
        repeat (n) begin
            @(negedge clk);
            idx = (cyc / RD) % 4;
            chk({tag, "_an"},  {4'b0, an_n},  {4'b0, ~(4'b0001 << idx)});
            chk({tag, "_seg"}, {1'b0, seg_n}, {1'b0, exp_seg(idx)});
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!res_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, {7'b0, res_ready}, 8'd1);
    endtask

    // One transaction: latency check, display held during conversion, then scan.
    task automatic send(input logic e, input logic [4:0] d, input string tag);
        int lows;
        int exp_lows;
        wait_ready(tag);
        res_valid = 1'b1; res_err = e; res_data = d;
        @(negedge clk);
        res_valid = 1'b0;
        lows = 0;
        while (!res_ready && lows < 8) begin
            chk({tag, "_hold"}, {1'b0, seg_n}, {1'b0, exp_seg((cyc / RD) % 4)});
            lows++;
            @(negedge clk);
        end
        exp_lows = (!e && d[3:0] >= 4'd10) ? 2 : 1;
        chk({tag, "_latency"}, 8'(lows), 8'(exp_lows));
        commit_model(e, d);
        check_scan(4 * RD + 1, tag);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_disp[i] = 7'h7F;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", {7'b0, res_ready}, 8'd1);
        chk("rst_an",    {4'b0, an_n},      8'h0E);
        chk("rst_seg",   {1'b0, seg_n},     8'h7F);
        rst_n = 1'b1;
        repeat (RD - 1) @(negedge clk);
        chk("scan_hold_an", {4'b0, an_n}, 8'h0E);
        @(negedge clk);
        chk("scan_step_an", {4'b0, an_n}, 8'h0D);
        check_scan(4 * RD, "blank_scan");

        // Directed results.
        send(1'b0, 5'b00011, "plus3");
        send(1'b0, 5'b11101, "minus13");
        send(1'b1, 5'b10101, "err");
        if (BLINK) check_scan((2 * BF + 1) * 4 * RD, "blink");
        send(1'b0, 5'b10000, "neg0");
        send(1'b0, 5'b01010, "plus10");

        // Second valid held during conversion of 14 is taken only after ready.
        wait_ready("held");
        res_valid = 1'b1; res_err = 1'b0; res_data = 5'b01110;
        @(negedge clk);
        res_data = 5'b10111;
        chk("held_busy1", {7'b0, res_ready}, 8'd0);
        @(negedge clk);
        chk("held_busy2", {7'b0, res_ready}, 8'd0);
        @(negedge clk);
        chk("held_done14", {7'b0, res_ready}, 8'd1);
        commit_model(1'b0, 5'b01110);
        chk("held_seg14", {1'b0, seg_n}, {1'b0, exp_seg((cyc / RD) % 4)});
        @(negedge clk);
        res_valid = 1'b0;
        chk("held_capt", {7'b0, res_ready}, 8'd0);
        @(negedge clk);
        chk("held_done7", {7'b0, res_ready}, 8'd1);
        commit_model(1'b0, 5'b10111);
        check_scan(4 * RD + 1, "held7");

        // Reset during conversion aborts it and blanks the display at once.
        wait_ready("midrst");
        res_valid = 1'b1; res_err = 1'b0; res_data = 5'b01101;
        @(negedge clk);
        res_valid = 1'b0;
        chk("midrst_busy", {7'b0, res_ready}, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {7'b0, res_ready}, 8'd1);
        chk("midrst_an",    {4'b0, an_n},      8'h0E);
        chk("midrst_seg",   {1'b0, seg_n},     8'h7F);
        for (int i = 0; i < 4; i++) exp_disp[i] = 7'h7F;
        exp_err = 1'b0;
        cyc_c   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_scan(4 * RD + 1, "midrst_scan");

        // Random results.
        for (int i = 0; i < 24; i++) begin
            logic       e;
            logic [4:0] d;
            e = ($urandom_range(0, 4) == 0);
            d = 5'($urandom);
            send(e, d, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
